// File: rtl/fc_classifier.sv
// Fully-connected classifier: serial MAC over the pooled 3x3 map for NUM_OUT outputs,
// followed by ReLU, shift, 8-bit saturation and a running argmax.
module fc_classifier #(
   parameter int NUM_OUT = 4,
   parameter int CLS_W   = 2,
   parameter int SHIFT   = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   fc_valid_i,
   input  logic [71:0]            fc_input,
   input  logic [NUM_OUT*72-1:0]  fc_weight,
   input  logic [NUM_OUT*16-1:0]  fc_bias,
   output logic                   fc_busy_o,
   output logic                   fc_valid_o,
   output logic [NUM_OUT*8-1:0]   fc_score_o,
   output logic [CLS_W-1:0]       fc_class_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      STORE = 2'd2
   } state_t;

   state_t                   state_r;
   logic [7:0]               x_r [9];
   logic [3:0]               in_idx_r;
   logic [CLS_W-1:0]         out_idx_r;
   logic [CLS_W-1:0]         best_r;
   logic [CLS_W-1:0]         class_r;
   logic signed [23:0]       acc_r;
   logic signed [23:0]       max_acc_r;
   logic [7:0]               score_r [NUM_OUT];
   logic                     valid_r;
   logic                     busy_r;

   logic signed [7:0]        w_s [NUM_OUT][9];
   logic signed [15:0]       b_s [NUM_OUT];
   logic [7:0]               in_s [9];

   logic [7:0]               x_sel_s;
   logic signed [7:0]        w_sel_s;
   logic signed [16:0]       prod_s;
   logic signed [23:0]       prod_ext_s;
   logic [CLS_W-1:0]         next_out_s;
   logic signed [15:0]       next_bias_s;
   logic [23:0]              relu_s;
   logic [23:0]              q_s;
   logic [7:0]               sat_s;
   logic                     last_out_s;
   logic                     new_max_s;

   for (genvar i = 0; i < 9; i++) begin : g_in
      assign in_s[i] = fc_input[(i+1)*8-1 -: 8];
   end

   for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
      assign b_s[o] = fc_bias[(o+1)*16-1 -: 16];
      assign fc_score_o[(o+1)*8-1 -: 8] = score_r[o];
      for (genvar i = 0; i < 9; i++) begin : g_w
         assign w_s[o][i] = fc_weight[(o*9+i+1)*8-1 -: 8];
      end
   end

   assign fc_busy_o  = busy_r;
   assign fc_valid_o = valid_r;
   assign fc_class_o = class_r;

   // MAC datapath and the ReLU / shift / saturate post-processing of the accumulator
   always_comb begin
      x_sel_s     = x_r[in_idx_r];
      w_sel_s     = w_s[out_idx_r][in_idx_r];
      prod_s      = $signed({1'b0, x_sel_s}) * w_sel_s;
      prod_ext_s  = {{7{prod_s[16]}}, prod_s};
      next_out_s  = out_idx_r + {{(CLS_W-1){1'b0}}, 1'b1};
      next_bias_s = b_s[next_out_s];
      last_out_s  = (out_idx_r == CLS_W'(NUM_OUT-1));
      new_max_s   = (acc_r > max_acc_r);
      if (acc_r[23]) begin
         relu_s = 24'd0;
      end else begin
         relu_s = acc_r;
      end
      q_s = relu_s >> SHIFT;
      if (q_s > 24'd255) begin
         sat_s = 8'hFF;
      end else begin
         sat_s = q_s[7:0];
      end
   end

   // Frame sequencer: accept, nine MAC steps per output, then store and argmax update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         in_idx_r  <= 4'd0;
         out_idx_r <= '0;
         best_r    <= '0;
         class_r   <= '0;
         acc_r     <= 24'sd0;
         max_acc_r <= 24'sd0;
         valid_r   <= 1'b0;
         busy_r    <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            x_r[i] <= 8'd0;
         end
         for (int o = 0; o < NUM_OUT; o++) begin
            score_r[o] <= 8'd0;
         end
      end else begin
         valid_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (fc_valid_i) begin
                  for (int i = 0; i < 9; i++) begin
                     x_r[i] <= in_s[i];
                  end
                  in_idx_r  <= 4'd0;
                  out_idx_r <= '0;
                  best_r    <= '0;
                  acc_r     <= {{8{b_s[0][15]}}, b_s[0]};
                  max_acc_r <= 24'sh800000;
                  busy_r    <= 1'b1;
                  state_r   <= MAC;
               end else begin
                  state_r   <= IDLE;
               end
            end
            MAC: begin
               acc_r <= acc_r + prod_ext_s;
               if (in_idx_r == 4'd8) begin
                  in_idx_r <= 4'd0;
                  state_r  <= STORE;
               end else begin
                  in_idx_r <= in_idx_r + 4'd1;
                  state_r  <= MAC;
               end
            end
            STORE: begin
               score_r[out_idx_r] <= sat_s;
               if (new_max_s) begin
                  max_acc_r <= acc_r;
                  best_r    <= out_idx_r;
               end else begin
                  max_acc_r <= max_acc_r;
               end
               if (!last_out_s) begin
                  out_idx_r <= next_out_s;
                  in_idx_r  <= 4'd0;
                  acc_r     <= {{8{next_bias_s[15]}}, next_bias_s};
                  state_r   <= MAC;
               end else begin
                  // Ties keep the earlier index, so only a strict win replaces best_r
                  class_r <= new_max_s ? out_idx_r : best_r;
                  valid_r <= 1'b1;
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/fc_classifier.md
Name: fc_classifier

Overview:
- Fully-connected output layer directly downstream of the 2x2 max-pool stage.
- Consumes the pooled 3x3 feature map (9 unsigned bytes, one frame per fc_valid_i pulse) and computes NUM_OUT class scores with one serial MAC.
- Each score is accumulator = bias + sum(x*w), then ReLU, right shift, saturation to 8 bits.
- Also reports the argmax class index; this is the last compute stage before the result interface.

Parameters:
- NUM_OUT, 4, number of output neurons/classes (>=2).
- CLS_W, 2, width of class index; must satisfy 2^CLS_W >= NUM_OUT.
- SHIFT, 4, right-shift applied to the ReLU'd accumulator before saturation (0..15).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- fc_valid_i  input  1  one-cycle frame strobe from max-pool
- fc_input  input  72  9 unsigned bytes; element i at bits [(i+1)*8-1 -: 8], i=0..8
- fc_weight  input  NUM_OUT*72  signed 8-bit weights; w[o][i] at index k=o*9+i, bits [(k+1)*8-1 -: 8]; static during a frame
- fc_bias  input  NUM_OUT*16  signed 16-bit bias; bias[o] at bits [(o+1)*16-1 -: 16]; static during a frame
- fc_busy_o  output  1  high while a frame is being processed
- fc_valid_o  output  1  one-cycle result strobe
- fc_score_o  output  NUM_OUT*8  unsigned quantised scores; score[o] at bits [(o+1)*8-1 -: 8]
- fc_class_o  output  CLS_W  index of the largest accumulator

Behaviour:
- Reset (async): state=IDLE; fc_busy_o=0, fc_valid_o=0, fc_score_o=0, fc_class_o=0; all internal counters, accumulators and registers cleared.
- Reset mid-frame aborts the frame; no fc_valid_o is produced.
- States: IDLE, MAC, STORE.
- IDLE, on an edge with fc_valid_i=1:
  - Register all 9 input bytes.
  - in_idx=0, out_idx=0, acc=sign-extended bias[0], max_acc=most negative 24-bit value.
  - Go to MAC.
- MAC, each edge:
  - acc += {1'b0,x[in_idx]} * w[out_idx][in_idx] (signed 9x8 -> 17-bit product, sign-extended to 24 bits).
  - in_idx increments; on in_idx==8 the accumulate is performed and state -> STORE.
- STORE, one edge:
  - r = acc<0 ? 0 : acc; q = r >>> SHIFT; score[out_idx] = q>255 ? 255 : q[7:0].
  - If acc > max_acc (strictly greater), update max_acc and record out_idx as the class. Ties keep the lower index.
  - If out_idx < NUM_OUT-1: out_idx++, in_idx=0, acc=bias[out_idx+1], state -> MAC.
  - Otherwise: commit the class to fc_class_o, fc_valid_o<=1, state -> IDLE.
- Accumulator width is 24 bits signed and never overflows (|sum| <= 9*255*128 + 2^15).
- Timing per output: 9 MAC edges + 1 STORE edge = 10 edges.
  - fc_valid_o rises on edge 10*NUM_OUT after the accept edge (40 for the default).
  - fc_valid_o stays high exactly one cycle.
- fc_score_o entries update as each STORE completes. They are only guaranteed coherent while fc_valid_o=1, and hold until overwritten by the next frame.
- fc_class_o changes only on the final STORE edge.
- fc_busy_o = (state != IDLE). It is high from the edge after accept through the final STORE edge.
- fc_valid_i while busy is ignored and dropped; no queueing, no effect on the current frame.
- fc_valid_i in the cycle fc_valid_o=1 is accepted (state is already IDLE).
- fc_weight/fc_bias changing while busy gives undefined scores; this is not checked.

Test Plan:
- SHIFT=0, all inputs=1, all weights=1, biases=0 -> scores {9,9,9,9}, class=0 (tie), fc_valid_o exactly 40 edges after accept, one cycle wide.
- SHIFT=0, inputs=10, weights of output 2 = 2, all others 1, biases 0 -> scores {90,90,180,90}, class=2.
- SHIFT=4, inputs=255, weights=127, biases=0 -> acc=291465 -> 18216 after shift -> all scores saturate to 255, class=0.
- SHIFT=0, inputs=1, weights=1, bias[o]={-5,0,-20,3} -> scores {4,9,0,12}, class=3.
- SHIFT=0, inputs=1, weights=-1 for outputs 0-2 and 1 for output 3, biases=0 -> scores {0,0,0,9}, class=3.
- Handshake/reset:
  - Second fc_valid_i pulse at accept+5 -> dropped, single fc_valid_o, results of first frame only.
  - Back-to-back pulse in the fc_valid_o cycle -> accepted, second fc_valid_o 40 edges later.
  - rst_n low at accept+20 -> all outputs 0, no fc_valid_o.
